pwm_timebase_ctr: RTL

//  Next-gen PWM timebase: W-bit counter with clock prescaler, edge- or center-aligned (up/down) counting,
//  and shadowed period/prescale/mode registers that commit only at period boundaries (glitch-free updates).

---
 rtl/pwm_timebase_ctr.sv | 73 +++++++
 1 files changed

// File: rtl/pwm_timebase_ctr.sv
// pwm_timebase_ctr: prescaled edge/center-aligned PWM timebase with period-boundary shadow commit
module pwm_timebase_ctr #(
  parameter int CNT_WIDTH             = 32,
  parameter int PRESC_WIDTH           = 8,
  parameter int DEFAULT_PERIOD_CYCLES = 5000,
  parameter int RST_CNT_WHEN_DISABLED = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   center_mode,
  input  logic [CNT_WIDTH-1:0]   period_cycles,
  input  logic [PRESC_WIDTH-1:0] prescale_div,
  output logic [CNT_WIDTH-1:0]   cnt,
  output logic                   dir_down,
  output logic                   tick,
  output logic                   period_start,
  output logic                   period_end,
  output logic                   period_mid,
  output logic                   shadow_load
);
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] TWO = CNT_WIDTH'(2);
  // a default below 2 would itself be an illegal period, so clamp it like a request
  localparam logic [CNT_WIDTH-1:0] DEF_P = DEFAULT_PERIOD_CYCLES < 2 ? TWO : CNT_WIDTH'(DEFAULT_PERIOD_CYCLES);
  logic [CNT_WIDTH-1:0]   p, pe_req;
  logic [PRESC_WIDTH-1:0] d, presc;
  logic                   m, term;
  always_comb begin
    pe_req       = period_cycles == '0 ? DEF_P : period_cycles == ONE ? TWO : period_cycles;
    tick         = enable && !rst && presc == d;
    term         = m ? (dir_down && cnt == ONE) : (cnt == p - ONE);
    period_end   = tick && term;
    period_start = tick && cnt == '0 && !dir_down;
    period_mid   = tick && m && cnt == p;
    shadow_load  = period_end;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      p        <= DEF_P;
      d        <= '0;
      m        <= 1'b0;
      cnt      <= '0;
      dir_down <= 1'b0;
      presc    <= '0;
    end else if (!enable) begin
      if (RST_CNT_WHEN_DISABLED != 0) begin
        cnt      <= '0;
        dir_down <= 1'b0;
        presc    <= '0;
        p        <= pe_req;
        d        <= prescale_div;
        m        <= center_mode;
      end
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (period_end) begin
        cnt      <= '0;
        dir_down <= 1'b0;
        p        <= pe_req;
        d        <= prescale_div;
        m        <= center_mode;
      end else if (tick) begin
        if (m && !dir_down && cnt == p) begin
          cnt      <= cnt - ONE;
          dir_down <= 1'b1;
        end else begin
          cnt <= dir_down ? cnt - ONE : cnt + ONE;
        end
      end
    end
  end
endmodule
